// File: rtl/imem_loader.sv
// imem_loader: byte-stream to instruction-memory loader.
// Packs little-endian words and holds the CPU while loading.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t          state;
  logic [1:0]      idx;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] cnt_nxt;

  assign cnt_nxt    = cnt + CNT_ONE;
  assign byte_ready = (state == RECV);

  // Load sequencer: collect four bytes, write one word, repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= '0;
      target    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            target   <= (word_count == '0) ? DEPTH_W
                                           : word_count;
            mem_addr <= '0;
            idx      <= 2'd0;
            cnt      <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            state    <= RECV;
          end
        end
        RECV: begin
          if (byte_valid) begin
            mem_wdata[{idx, 3'b000} +: 8] <= byte_in;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              mem_we <= 1'b1;
              state  <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we <= 1'b0;
          cnt    <= cnt_nxt;
          if (cnt_nxt == target) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_addr <= mem_addr + ADDR_ONE;
            idx      <= 2'd0;
            state    <= RECV;
          end
        end
        DONE: begin
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory: accepts a byte stream (valid/ready) from a host link and assembles little-endian 32-bit instruction words.
- Writes each word into consecutive instruction-memory word addresses starting at 0, through the memory's write port.
- Holds the CPU (cpu_hold) for the whole load, so the fetch side never reads a partially written program.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory.
- ADDR_W, 6, word-address width; log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  in  ADDR_W+1  number of words to load; sampled on the accepted start; 0 means DEPTH.
- byte_in  in  8  incoming program byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  instruction-memory word address.
- mem_wdata  out  32  instruction word to write.
- cpu_hold  out  1  holds the CPU in reset/stall while a load is in progress.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final word has been written.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - byte_ready, mem_we, cpu_hold, busy and done all 0.
  - mem_addr=0, mem_wdata=0, byte index=0, word counter=0.
  - Reset mid-load: partial word discarded, no write issued; after release the loader waits in IDLE for a new start.
- States: IDLE, RECV, WRITE, DONE. All outputs are registered except byte_ready, which is (state==RECV).
- IDLE:
  - start=1 latches target = (word_count==0 ? DEPTH : word_count).
  - Same edge clears mem_addr, byte index and word counter, then goes to RECV.
  - cpu_hold and busy rise on that edge.
- RECV:
  - A byte is accepted on an edge where byte_valid && byte_ready.
  - Byte k (k=0..3) goes into mem_wdata[8k+7:8k]; the first byte received is the LSB.
  - byte_valid=0 stalls the loader indefinitely; no timeout.
  - The edge that accepts byte 3 moves the loader to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = current word index, mem_wdata = assembled word; byte_ready=0.
  - The memory captures the write on the next edge.
  - On that edge mem_we drops and the word counter increments.
  - If the counter reaches target, go to DONE; otherwise mem_addr increments, byte index clears and the loader returns to RECV.
- DONE (one cycle): done=1 and cpu_hold=0 on the edge leaving DONE; busy=0 from IDLE onward.
- cpu_hold is high from the cycle after the accepted start through the DONE cycle, inclusive.
- Throughput: at most one word per 5 cycles (4 accept cycles + 1 write cycle).
- mem_addr after the last write holds target-1 and must not wrap. For target=DEPTH the final write goes to address DEPTH-1.
- start while busy is ignored; word_count changes while busy are ignored.
- byte_valid asserted in IDLE/WRITE/DONE: the byte is not consumed (byte_ready=0); the source must hold it.
- mem_wdata holds its last value when mem_we=0; it is don't-care for the memory.

Test Plan:
- Reset/idle:
  - Stimulus: rst_n=0, then release.
  - Required: all outputs 0; byte_valid=1 with 0xAA is never accepted (byte_ready=0) while start=0.
- Single word:
  - Stimulus: word_count=1, start, bytes 0x83,0x20,0x00,0x00 back-to-back.
  - Required: exactly one mem_we pulse with addr=0, wdata=0x00002083 (lw x1,0(x0)); done pulse the cycle after; cpu_hold is 1 for 6 cycles.
- Multi-word with stalls:
  - Stimulus: word_count=3, bytes for 0x00002083, 0x00402103, 0x00802183, with byte_valid randomly deasserted.
  - Required: writes to addr 0,1,2 in order with those values; no byte lost or duplicated.
- Full depth:
  - Stimulus: word_count=0 (meaning 64), 256 bytes where word i = i*0x01010101.
  - Required: 64 writes; last at addr 63 = 0x3F3F3F3F; mem_addr does not wrap to 0.
- Reset mid-word:
  - Stimulus: after 2 bytes of word 1, assert rst_n=0.
  - Required: mem_we stays 0 and cpu_hold drops immediately.
  - Follow-up: a new load of 1 word writes addr 0 with no stale bytes.
- start while busy:
  - Stimulus: pulse start during RECV of word 0 with word_count=5 (original load word_count=2).
  - Required: load completes after exactly 2 words; no restart.
